// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM state
// encoding and the request legality check used at request acceptance.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // A request is legal when its size code exists, unsigned sizes are only
  // used by loads, and the address is naturally aligned for the size.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = ~we;
      F3_H:    ok = ~addr_lo[0];
      F3_HU:   ok = ~we & ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational little-endian lane handling.
//   rword_i      : word currently read from memory
//   wdata_i      : store data (low bits used)
//   addr_lo_i    : byte offset within the word
//   funct3_i     : size code
//   load_data_o  : selected lane, sign/zero extended (W passes through)
//   merge_data_o : rword_i with the store lane replaced (B/H only)
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection for loads.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_s = rword_i[7:0];
      2'd1:    byte_s = rword_i[15:8];
      2'd2:    byte_s = rword_i[23:16];
      2'd3:    byte_s = rword_i[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Extension of the selected lane.
  always_comb begin
    load_data_o = 32'h0000_0000;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data_o = {24'h00_0000, byte_s};
      F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data_o = {16'h0000, half_s};
      F3_W:    load_data_o = rword_i;
      default: load_data_o = 32'h0000_0000;
    endcase
  end

  // Read-modify-write merge: only the addressed lane is replaced.
  always_comb begin
    merge_data_o = rword_i;
    case (funct3_i)
      F3_B: begin
        case (addr_lo_i)
          2'd0:    merge_data_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_data_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_data_o[23:16] = wdata_i[7:0];
          2'd3:    merge_data_o[31:24] = wdata_i[7:0];
          default: merge_data_o = rword_i;
        endcase
      end
      F3_H: begin
        if (addr_lo_i[1]) begin
          merge_data_o[31:16] = wdata_i[15:0];
        end else begin
          merge_data_o[15:0] = wdata_i[15:0];
        end
      end
      default: merge_data_o = rword_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU datapath and a single-port DRAM.
//   clk, rst             : clock, synchronous active-high reset
//   req_*                : valid/ready request (we, funct3, byte addr, wdata)
//   resp_*               : valid/ready completion (extended rdata, err)
//   mem_a/mem_we/mem_d   : DRAM word address, write enable, write data
//   mem_spo              : DRAM combinational read data
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_BITS-1:0] mem_a,
  output logic                 mem_we,
  output logic [31:0]          mem_d,
  input  logic [31:0]          mem_spo
);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [2:0]             f3_q, f3_d;
  logic [1:0]             addr_lo_q, addr_lo_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_rdata_q, resp_rdata_d;
  logic                   resp_err_q, resp_err_d;
  logic [ADDR_BITS-1:0]   mem_a_q, mem_a_d;
  logic                   mem_we_q, mem_we_d;
  logic [31:0]            mem_d_q, mem_d_d;
  logic [31:0]            load_data_s;
  logic [31:0]            merge_data_s;
  logic                   unused_addr_s;

  // High byte-address bits wrap silently.
  assign unused_addr_s = ^req_addr[31:ADDR_BITS+2];

  lane_align u_lane_align (
    .rword_i      (mem_spo),
    .wdata_i      (wdata_q),
    .addr_lo_i    (addr_lo_q),
    .funct3_i     (f3_q),
    .load_data_o  (load_data_s),
    .merge_data_o (merge_data_s)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_a_d      = mem_a_q;
    mem_we_d     = 1'b0;
    mem_d_d      = mem_d_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d         = req_we;
          f3_d         = req_funct3;
          addr_lo_d    = req_addr[1:0];
          wdata_d      = req_wdata;
          req_ready_d  = 1'b0;
          resp_rdata_d = 32'h0000_0000;
          if (!is_legal(req_we, req_funct3, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ST_ACCESS;
            resp_err_d = 1'b0;
            mem_a_d    = req_addr[ADDR_BITS+1:2];
            // A full-word store needs no read, so it writes during ACCESS.
            if (req_we && (req_funct3 == F3_W)) begin
              mem_we_d = 1'b1;
              mem_d_d  = req_wdata;
            end else begin
              mem_we_d = 1'b0;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          resp_rdata_d = load_data_s;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else if (f3_q == F3_W) begin
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          // mem_d_q doubles as the merge word written back in WRITE.
          mem_d_d  = merge_data_s;
          mem_we_d = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_lo_q    <= 2'b00;
      wdata_q      <= 32'h0000_0000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
      mem_a_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_d_q      <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_a_q      <= mem_a_d;
      mem_we_q     <= mem_we_d;
      mem_d_q      <= mem_d_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_a      = mem_a_q;
  assign mem_d      = mem_d_q;
  // Masking with rst keeps a reset that lands in WRITE from committing a
  // half-finished read-modify-write at the reset edge.
  assign mem_we     = mem_we_q & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_d, mem_spo;

  logic [31:0] dmem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_spo(mem_spo)
  );

  // DRAM model: combinational read, write on posedge; pl_en is a backdoor preload.
  assign mem_spo = dmem[mem_a[7:0]];
  always @(posedge clk) begin
    if (pl_en) dmem[pl_idx] <= pl_data;
    else if (mem_we) dmem[mem_a[7:0]] <= mem_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx[7:0]; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  // One transaction with reference-model expectations; hold = cycles resp_ready stays low.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
    int size, off, idx, lat, pulses, exp_lat, exp_pulses;
    logic legal, exp_err;
    logic [31:0] old, v, mask, new_w, exp_rd, wa, wdv;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    legal = (size != 0) && !(we && f3 >= 3'd4) && ((addr % size) == 0);
    off = int'(addr % 4);
    idx = int'((addr >> 2) & 32'hFF);
    old = ref_mem[idx];
    new_w = old; exp_rd = 32'h0; exp_err = 1'b0; exp_pulses = 0;
    if (!legal) begin
      exp_err = 1'b1; exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      v = old >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      exp_rd = v;
    end else begin
      exp_lat = (size == 4) ? 2 : 3;
      exp_pulses = 1;
      mask = ((size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF) << (8 * off);
      new_w = (old & ~mask) | ((wd << (8 * off)) & mask);
      ref_mem[idx] = new_w;
    end

    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1; pulses = 0; wa = 32'h0; wdv = 32'h0;
    while (!resp_valid && lat < 8) begin
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      if (mem_we) begin pulses++; wa = {16'd0, mem_a}; wdv = mem_d; end
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("latency", lat, exp_lat);
    chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("we_pulses", pulses, exp_pulses);
    chk("we_in_resp", {31'd0, mem_we}, 32'd0);
    chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
    if (exp_pulses == 1) begin
      chk("write_addr", wa, (addr >> 2) & 32'hFFFF);
      chk("write_data", wdv, new_w);
    end
    last_rd = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_we", {31'd0, mem_we}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_done", {31'd0, resp_valid}, 32'd0);
    chk("ready_again", {31'd0, req_ready}, 32'd1);
    chk("mem_word", dmem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] old1;
    logic        saw_valid;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) preload(i, $urandom);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_a", {16'd0, mem_a}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_d", mem_d, 32'd0);
    rst = 1'b0;
    preload(0, 32'h8070_6050);
    preload(1, 32'h1122_3344);

    do_req(1'b0, 3'b000, 32'h3, 32'h0, 0);  chk("lb3", last_rd, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h3, 32'h0, 0);  chk("lbu3", last_rd, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h2, 32'h0, 0);  chk("lh2", last_rd, 32'hFFFF_8070);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 0);  chk("lw0", last_rd, 32'h8070_6050);
    do_req(1'b1, 3'b000, 32'h5, 32'hAB, 0);
    chk("sb_word1", dmem[1], 32'h1122_AB44);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 0);  chk("lw4", last_rd, 32'h1122_AB44);
    do_req(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 0);
    chk("sw_word2", dmem[2], 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h6, 32'h0, 0);
    do_req(1'b1, 3'b001, 32'h1, 32'h1234, 0);
    do_req(1'b0, 3'b011, 32'h0, 32'h0, 0);
    do_req(1'b1, 3'b100, 32'h0, 32'h55, 0);
    do_req(1'b0, 3'b010, 32'h8, 32'h0, 5);  chk("lw8_held", last_rd, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b101, 32'h0004_0006, 32'h0, 0);  chk("lhu_wrap", last_rd, 32'h0000_1122);

    // Reset landing in the WRITE cycle of an SH.
    old1 = ref_mem[1];
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h6; req_wdata = 32'h0000_9999;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("sh_write_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_we_low", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk("rst_we_after", {31'd0, mem_we}, 32'd0);
    chk("rst_idle_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    saw_valid = resp_valid;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | resp_valid;
    end
    chk("rst_no_resp", {31'd0, saw_valid}, 32'd0);
    chk("rst_mem_kept", dmem[1], old1);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 0);  chk("lw4_after_rst", last_rd, old1);

    // Random traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      a = $urandom & 32'h0000_00FF;
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFC_0000);
      do_req(1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
